// File: rtl/signed_bcd_display.sv
// signed_bcd_display
// Converts a signed two's-complement value to decimal with a sequential
// double-dabble engine and drives a bank of active-low seven-segment digits.
// An overflow request shows a blinking "OF" message instead of the value.
//
// Handshake: a request is taken on any rising edge where load=1 and busy=0.
// value/overflow are sampled on that edge only. While busy=1, load is
// ignored and never queued. done pulses for exactly one cycle, and that is
// the first cycle the new display is visible. busy is already low in that
// cycle, so a new load there is accepted.
module signed_bcd_display #(
    parameter int WIDTH     = 8,
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      value,
    input  logic                  overflow,
    input  logic                  load,
    input  logic                  blank,
    output logic                  busy,
    output logic                  done,
    output logic [8*DIGITS-1:0]   hex_out
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAX_MAG = 64'd1 << (WIDTH - 1);

    // Reject parameter sets the display cannot represent.
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("signed_bcd_display: WIDTH must be in 2..16");
    end
    if (MAX_MAG >= pow10(DIGITS - 1)) begin : g_bad_digits
        $error("signed_bcd_display: DIGITS too small for WIDTH plus sign");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("signed_bcd_display: BLINK_DIV must be >= 1");
    end

    localparam int BW    = 4 * DIGITS;            // BCD field width
    localparam int WW    = BW + WIDTH;            // BCD field + magnitude shifter
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int BLK_W = $clog2(BLINK_DIV) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_UPDATE  = 2'd2;

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [1:0]          r_state;
    logic [WW-1:0]       r_work;      // {BCD digits, remaining magnitude bits}
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_sign;
    logic                r_ovf;
    logic                r_done;
    logic [8*DIGITS-1:0] r_disp;      // stored result, unblanked
    logic                r_show_ovf;  // stored result is the overflow message
    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_visible;
    logic [8*DIGITS-1:0] r_hex;

    logic [WIDTH-1:0]    w_mag;
    logic [WW-1:0]       w_work_adj;
    logic [BW-1:0]       w_bcd;
    int                  w_msd;
    logic [8*DIGITS-1:0] w_new_disp;
    logic                w_update;
    logic                w_blink_wrap;
    logic                w_visible_next;
    logic [8*DIGITS-1:0] w_src_disp;
    logic                w_src_ovf;
    logic [8*DIGITS-1:0] w_hex_next;

    // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign w_mag = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;
    assign w_bcd = r_work[WW-1 -: BW];

    // Add-3 correction on every BCD digit that is 5 or more.
    always_comb begin
        w_work_adj = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[WIDTH + 4*i +: 4] >= 4'd5)
                w_work_adj[WIDTH + 4*i +: 4] = r_work[WIDTH + 4*i +: 4] + 4'd3;
        end
    end

    // Build the segment pattern for the finished conversion.
    always_comb begin
        w_msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0) w_msd = i;
        end
        w_new_disp = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_ovf) begin
                if (k == 0)      w_new_disp[8*k +: 8] = SEG_F;
                else if (k == 1) w_new_disp[8*k +: 8] = SEG_O;
            end else if (k <= w_msd) begin
                w_new_disp[8*k +: 8] = seg7(w_bcd[4*k +: 4]);
            end else if (k == w_msd + 1 && r_sign && (w_bcd != '0)) begin
                w_new_disp[8*k +: 8] = SEG_MINUS;
            end
        end
    end

    // Control FSM: capture request, shift WIDTH magnitude bits, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_work    <= '0;
            r_bit_cnt <= '0;
            r_sign    <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_work    <= {{BW{1'b0}}, w_mag};
                        r_bit_cnt <= '0;
                        r_sign    <= value[WIDTH-1];
                        r_ovf     <= overflow;
                        r_state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    // Rotate rather than shift: the top BCD bit is always zero
                    // because the magnitude fits in DIGITS-1 digits, so the
                    // wrapped bit just refills the vacated shifter LSB.
                    r_work    <= {w_work_adj[WW-2:0], w_work_adj[WW-1]};
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_BIT) r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_update     = (r_state == S_UPDATE);
    assign w_blink_wrap = r_show_ovf && (r_blink_cnt == BLINK_LAST);

    always_comb begin
        w_src_disp     = w_update ? w_new_disp : r_disp;
        w_src_ovf      = w_update ? r_ovf : r_show_ovf;
        w_visible_next = w_update ? 1'b1 : (w_blink_wrap ? ~r_visible : r_visible);
        if (blank)
            w_hex_next = '1;
        else if (w_src_ovf && !w_visible_next)
            w_hex_next = {DIGITS{SEG_BLANK}};
        else
            w_hex_next = w_src_disp;
    end

    // Result storage, blink timing and the registered segment outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= '1;
            r_show_ovf  <= 1'b0;
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
            r_hex       <= '1;
        end else begin
            if (w_update) begin
                r_disp      <= w_new_disp;
                r_show_ovf  <= r_ovf;
                r_blink_cnt <= '0;
            end else if (r_show_ovf) begin
                r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLK_W'(1);
            end
            r_visible <= w_visible_next;
            r_hex     <= w_hex_next;
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign hex_out = r_hex;

endmodule

// File: tb/tb_signed_bcd_display.sv
// Bench for signed_bcd_display: directed literal checks plus random traffic
// compared every cycle against a decimal-arithmetic display model.
module tb_signed_bcd_display;
  localparam int W  = 8;
  localparam int D  = 6;
  localparam int BD = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [W-1:0]   value = '0;
  logic           overflow = 1'b0;
  logic           load = 1'b0;
  logic           blank = 1'b0;
  logic           busy;
  logic           done;
  logic [8*D-1:0] hex_out;

  int n_checks = 0;
  int n_fail   = 0;

  signed_bcd_display #(.WIDTH(W), .DIGITS(D), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .overflow(overflow),
    .load(load), .blank(blank), .busy(busy), .done(done), .hex_out(hex_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [8*D-1:0] exp_disp(input int v, input bit ovf);
    logic [8*D-1:0] res;
    int mag;
    int k;
    res = '1;
    if (ovf) begin
      res[15:0] = 16'hC08E;
      return res;
    end
    mag = (v < 0) ? -v : v;
    k = 0;
    do begin
      res[8*k +: 8] = seg_tab[mag % 10];
      mag = mag / 10;
      k++;
    end while (mag != 0);
    if (v < 0) res[8*k +: 8] = 8'hBF;
    return res;
  endfunction

  int             m_left;
  int             m_val;
  bit             m_ovf_cap;
  logic [8*D-1:0] m_disp;
  bit             m_show_ovf;
  int             m_age;
  bit             m_hidden;
  logic           e_busy;
  logic           e_done;
  logic [8*D-1:0] e_hex;

  // A request accepted at an edge becomes visible W+1 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_disp = '1; m_show_ovf = 0; m_age = 0;
      e_busy = 0; e_done = 0; e_hex = '1;
    end else begin
      e_done = 0;
      if (m_left == 0) begin
        if (load) begin
          m_left = W + 1;
          m_val = int'($signed(value));
          m_ovf_cap = overflow;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_disp = exp_disp(m_val, m_ovf_cap);
          m_show_ovf = m_ovf_cap;
          m_age = -1;
          e_done = 1;
        end
      end
      m_age++;
      m_hidden = m_show_ovf && (((m_age / BD) % 2) == 1);
      e_busy = (m_left != 0);
      e_hex = blank ? '1 : (m_hidden ? '1 : m_disp);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("hex_out", 64'(hex_out), 64'(e_hex));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the following negedge.
  task automatic do_load(input int v, input bit ovf);
    value = 8'(v);
    overflow = ovf;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    value = 8'($urandom);
    overflow = 1'($urandom);
  endtask

  // Entered on the negedge after the accept edge; returns on the done negedge.
  task automatic wait_done(output int edges, output int busy_cycles);
    int n;
    n = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_cycles++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
    edges = n - 1;
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int lat, bc, dc;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_hex", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // zero, latency and busy length
    do_load(0, 0);
    wait_done(lat, bc);
    chk("zero_latency", 64'(lat), 64'(W + 1));
    chk("zero_busy_cycles", 64'(bc), 64'(W + 1));
    chk("zero_hex", 64'(hex_out), 64'hFFFF_FFFF_FFC0);

    // extremes
    do_load(-128, 0);
    wait_done(lat, bc);
    chk("neg128_hex", 64'(hex_out), 64'hFFFF_BFF9_A480);
    do_load(127, 0);
    wait_done(lat, bc);
    chk("pos127_hex", 64'(hex_out), 64'hFFFF_FFF9_A4F8);

    do_load(-5, 0);
    wait_done(lat, bc);
    chk("neg5_hex", 64'(hex_out), 64'hFFFF_FFFF_BF92);
    do_load(10, 0);
    wait_done(lat, bc);
    chk("pos10_hex", 64'(hex_out), 64'hFFFF_FFFF_F9C0);

    // overflow blink
    do_load(0, 1);
    wait_done(lat, bc);
    chk("ovf_vis0", 64'(hex_out), 64'hFFFF_FFFF_C08E);
    repeat (3) @(negedge clk);
    chk("ovf_vis3", 64'(hex_out), 64'hFFFF_FFFF_C08E);
    @(negedge clk);
    chk("ovf_off0", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    chk("ovf_off3", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
    @(negedge clk);
    chk("ovf_vis_again", 64'(hex_out), 64'hFFFF_FFFF_C08E);
    do_load(3, 0);
    wait_done(lat, bc);
    chk("three_hex", 64'(hex_out), 64'hFFFF_FFFF_FFB0);
    repeat (6) @(negedge clk);
    chk("three_steady", 64'(hex_out), 64'hFFFF_FFFF_FFB0);

    // load while busy is dropped, load on done is taken
    do_load(42, 0);
    repeat (2) @(negedge clk);
    do_load(99, 0);
    wait_done(lat, bc);
    chk("busy_load_hex", 64'(hex_out), 64'hFFFF_FFFF_99A4);
    do_load(-1, 0);
    wait_done(lat, bc);
    chk("done_load_latency", 64'(lat), 64'(W + 1));
    chk("done_load_hex", 64'(hex_out), 64'hFFFF_FFFF_BFF9);
    count_done(12, dc);
    chk("no_extra_done", 64'(dc), 64'd0);

    // reset during conversion
    do_load(55, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hex", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(15, dc);
    chk("abort_no_done", 64'(dc), 64'd0);

    // blank
    do_load(7, 0);
    wait_done(lat, bc);
    chk("seven_hex", 64'(hex_out), 64'hFFFF_FFFF_FFF8);
    blank = 1'b1;
    @(negedge clk);
    chk("blank_on", 64'(hex_out), 64'hFFFF_FFFF_FFFF);
    blank = 1'b0;
    @(negedge clk);
    chk("blank_off", 64'(hex_out), 64'hFFFF_FFFF_FFF8);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      load     = ($urandom_range(0, 3) == 0);
      value    = 8'($urandom);
      overflow = ($urandom_range(0, 7) == 0);
      blank    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    blank = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
